// File: rtl/pc_pkg.sv
// Shared types and constants for the PC generator and its redirect buffer.
package pc_pkg;

  // Redirect buffer state: RUN has nothing waiting, HOLD has a captured redirect.
  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  // Kind of redirect held in the buffer; TRAP outranks BR when overwriting.
  typedef enum logic [1:0] {
    NONE,
    BR,
    TRAP
  } kind_t;

  // Default sequential increment (one 32-bit instruction).
  localparam int DEFAULT_INC = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Request/response bundle between the pipeline control and the PC generator.
// The master side raises stalls and redirects; the slave side (pc_gen) returns
// the fetch PC and status pulses.
interface pc_gen_if #(
  parameter int WIDTH  = 32,
  parameter int NSTALL = 3
);

  logic [NSTALL-1:0] stall;
  logic              trap_valid;
  logic [WIDTH-1:0]  trap_target;
  logic              br_valid;
  logic [WIDTH-1:0]  br_target;
  logic [WIDTH-1:0]  pc_out;
  logic [WIDTH-1:0]  pc_prev;
  logic              redir_taken;
  logic              pending;
  logic              misalign;

  modport master (
    output stall, trap_valid, trap_target, br_valid, br_target,
    input  pc_out, pc_prev, redir_taken, pending, misalign
  );

  modport slave (
    input  stall, trap_valid, trap_target, br_valid, br_target,
    output pc_out, pc_prev, redir_taken, pending, misalign
  );

endinterface

// File: rtl/pc_redir_buf.sv
// Holds a redirect that arrives while the fetch stage is stalled so it is not
// lost. A trap may replace anything buffered; a branch may only replace an
// earlier branch. The first go cycle hands the buffer to the PC mux and clears it.
module pc_redir_buf
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_target,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  output logic             pending,
  output logic [WIDTH-1:0] buf_target
);

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [WIDTH-1:0] target_q, target_d;

  // State, kind and raw target registers; reset drops any buffered redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      kind_q   <= NONE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      target_q <= target_d;
    end
  end

  // Capture and overwrite rules; the raw target is kept so misalign can be
  // judged when the redirect is finally applied.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    target_d = target_q;
    case (state_q)
      RUN: begin
        if (!go) begin
          if (trap_valid) begin
            state_d  = HOLD;
            kind_d   = TRAP;
            target_d = trap_target;
          end else if (br_valid) begin
            state_d  = HOLD;
            kind_d   = BR;
            target_d = br_target;
          end
        end
      end
      HOLD: begin
        if (go) begin
          state_d  = RUN;
          kind_d   = NONE;
          target_d = '0;
        end else if (trap_valid) begin
          kind_d   = TRAP;
          target_d = trap_target;
        end else if (br_valid && (kind_q != TRAP)) begin
          kind_d   = BR;
          target_d = br_target;
        end
      end
      default: begin
        state_d  = RUN;
        kind_d   = NONE;
        target_d = '0;
      end
    endcase
  end

  assign pending    = (state_q == HOLD);
  assign buf_target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator. Advances by INC in go cycles (no stall source active),
// or jumps to a trap, buffered or branch target in that priority order.
// Targets are word-aligned on the way in; a misaligned raw target is flagged.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               NSTALL    = 3,
  parameter int               INC       = DEFAULT_INC
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);

  logic [NSTALL-1:0] stall_vec;
  logic              go;
  logic              buf_pending;
  logic [WIDTH-1:0]  buf_target;
  logic              sel_redir;
  logic [WIDTH-1:0]  sel_target;
  logic [WIDTH-1:0]  pc_next;
  logic [WIDTH-1:0]  pc_q;
  logic [WIDTH-1:0]  pc_prev_q;
  logic              redir_q;
  logic              misalign_q;

  assign stall_vec = bus.stall;
  assign go        = ~|stall_vec;

  pc_redir_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .trap_valid (bus.trap_valid),
    .trap_target(bus.trap_target),
    .br_valid   (bus.br_valid),
    .br_target  (bus.br_target),
    .pending    (buf_pending),
    .buf_target (buf_target)
  );

  // Priority mux: trap, then buffered redirect, then branch, then increment.
  always_comb begin
    sel_redir  = 1'b0;
    sel_target = '0;
    if (bus.trap_valid) begin
      sel_redir  = 1'b1;
      sel_target = bus.trap_target;
    end else if (buf_pending) begin
      sel_redir  = 1'b1;
      sel_target = buf_target;
    end else if (bus.br_valid) begin
      sel_redir  = 1'b1;
      sel_target = bus.br_target;
    end
    pc_next = sel_redir ? {sel_target[WIDTH-1:2], 2'b00} : pc_q + WIDTH'(INC);
  end

  // PC and pc_prev update only in go cycles; the pulses mark the cycle the new PC is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_VEC;
      pc_prev_q  <= RESET_VEC;
      redir_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else if (go) begin
      pc_q       <= pc_next;
      pc_prev_q  <= pc_q;
      redir_q    <= sel_redir;
      misalign_q <= sel_redir & (|sel_target[1:0]);
    end else begin
      redir_q    <= 1'b0;
      misalign_q <= 1'b0;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_prev     = pc_prev_q;
  assign bus.redir_taken = redir_q;
  assign bus.misalign    = misalign_q;
  assign bus.pending     = buf_pending;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each task drives one scenario and checks the
// outputs one cycle at a time against hand-computed values.
module tb_pc_gen;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  pc_gen_if #(.WIDTH(32), .NSTALL(3)) bus ();

  pc_gen #(
    .WIDTH    (32),
    .RESET_VEC(32'h0),
    .NSTALL   (3),
    .INC      (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [2:0] st,
                               input logic tv, input logic [31:0] tt,
                               input logic bv, input logic [31:0] bt);
    rst             = r;
    bus.stall       = st;
    bus.trap_valid  = tv;
    bus.trap_target = tt;
    bus.br_valid    = bv;
    bus.br_target   = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0, 1'b1, 32'h500);
    tick();
    tick();
    checks++; if (bus.pc_out !== 32'h0) begin fails++; $display("[TB] FAIL rst_pc: got %h want %h", bus.pc_out, 32'h0); end
    checks++; if (bus.pc_prev !== 32'h0) begin fails++; $display("[TB] FAIL rst_prev: got %h want %h", bus.pc_prev, 32'h0); end
    checks++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL rst_pending: got %b want 0", bus.pending); end
    checks++; if (bus.redir_taken !== 1'b0) begin fails++; $display("[TB] FAIL rst_redir: got %b want 0", bus.redir_taken); end
    checks++; if (bus.misalign !== 1'b0) begin fails++; $display("[TB] FAIL rst_misalign: got %b want 0", bus.misalign); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.pc_out !== exp_pc[i]) begin fails++; $display("[TB] FAIL seq_pc%0d: got %h want %h", i, bus.pc_out, exp_pc[i]); end
    end
    checks++; if (bus.pc_prev !== 32'hC) begin fails++; $display("[TB] FAIL seq_prev: got %h want %h", bus.pc_prev, 32'hC); end
  endtask

  task automatic test_stall_branch();
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    checks++; if (bus.pc_out !== 32'h10) begin fails++; $display("[TB] FAIL sb_hold1: got %h want %h", bus.pc_out, 32'h10); end
    checks++; if (bus.pending !== 1'b1) begin fails++; $display("[TB] FAIL sb_pend1: got %b want 1", bus.pending); end
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h10) begin fails++; $display("[TB] FAIL sb_hold2: got %h want %h", bus.pc_out, 32'h10); end
    checks++; if (bus.redir_taken !== 1'b0) begin fails++; $display("[TB] FAIL sb_redir_early: got %b want 0", bus.redir_taken); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h200) begin fails++; $display("[TB] FAIL sb_pc: got %h want %h", bus.pc_out, 32'h200); end
    checks++; if (bus.redir_taken !== 1'b1) begin fails++; $display("[TB] FAIL sb_redir: got %b want 1", bus.redir_taken); end
    checks++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL sb_pend0: got %b want 0", bus.pending); end
    checks++; if (bus.pc_prev !== 32'h10) begin fails++; $display("[TB] FAIL sb_prev: got %h want %h", bus.pc_prev, 32'h10); end
    tick();
    checks++; if (bus.pc_out !== 32'h204) begin fails++; $display("[TB] FAIL sb_next: got %h want %h", bus.pc_out, 32'h204); end
    checks++; if (bus.redir_taken !== 1'b0) begin fails++; $display("[TB] FAIL sb_redir_pulse: got %b want 0", bus.redir_taken); end
  endtask

  task automatic test_trap_overwrite();
    applyStimulus(1'b0, 3'b001, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 3'b001, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 3'b100, 1'b0, 32'h0, 1'b1, 32'h300);
    tick();
    checks++; if (bus.pc_out !== 32'h204) begin fails++; $display("[TB] FAIL tow_hold: got %h want %h", bus.pc_out, 32'h204); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h80) begin fails++; $display("[TB] FAIL tow_pc: got %h want %h", bus.pc_out, 32'h80); end
    checks++; if (bus.pc_prev !== 32'h204) begin fails++; $display("[TB] FAIL tow_prev: got %h want %h", bus.pc_prev, 32'h204); end
    checks++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL tow_pend: got %b want 0", bus.pending); end
    tick();
    checks++; if (bus.pc_out !== 32'h84) begin fails++; $display("[TB] FAIL tow_next: got %h want %h", bus.pc_out, 32'h84); end
  endtask

  task automatic test_trap_vs_branch();
    applyStimulus(1'b0, 3'b000, 1'b1, 32'h80, 1'b1, 32'h40);
    tick();
    checks++; if (bus.pc_out !== 32'h80) begin fails++; $display("[TB] FAIL tvb_pc: got %h want %h", bus.pc_out, 32'h80); end
    checks++; if (bus.pc_prev !== 32'h84) begin fails++; $display("[TB] FAIL tvb_prev: got %h want %h", bus.pc_prev, 32'h84); end
    checks++; if (bus.redir_taken !== 1'b1) begin fails++; $display("[TB] FAIL tvb_redir: got %b want 1", bus.redir_taken); end
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h0, 1'b1, 32'h600);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b1, 32'h700, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h700) begin fails++; $display("[TB] FAIL tvb_newtrap: got %h want %h", bus.pc_out, 32'h700); end
    checks++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL tvb_clear: got %b want 0", bus.pending); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h704) begin fails++; $display("[TB] FAIL tvb_nobuf: got %h want %h", bus.pc_out, 32'h704); end
  endtask

  task automatic test_stalled_rules();
    applyStimulus(1'b0, 3'b111, 1'b1, 32'h900, 1'b1, 32'hA00);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h900) begin fails++; $display("[TB] FAIL both_trap: got %h want %h", bus.pc_out, 32'h900); end
    applyStimulus(1'b0, 3'b100, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 3'b001, 1'b0, 32'h0, 1'b1, 32'h300);
    tick();
    checks++; if (bus.pc_out !== 32'h900) begin fails++; $display("[TB] FAIL br_hold: got %h want %h", bus.pc_out, 32'h900); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h300) begin fails++; $display("[TB] FAIL br_over: got %h want %h", bus.pc_out, 32'h300); end
  endtask

  task automatic test_misalign_wrap();
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b1, 32'h103);
    tick();
    checks++; if (bus.pc_out !== 32'h100) begin fails++; $display("[TB] FAIL mis_pc: got %h want %h", bus.pc_out, 32'h100); end
    checks++; if (bus.misalign !== 1'b1) begin fails++; $display("[TB] FAIL mis_pulse: got %b want 1", bus.misalign); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.misalign !== 1'b0) begin fails++; $display("[TB] FAIL mis_end: got %b want 0", bus.misalign); end
    checks++; if (bus.pc_out !== 32'h104) begin fails++; $display("[TB] FAIL mis_next: got %h want %h", bus.pc_out, 32'h104); end
    applyStimulus(1'b0, 3'b010, 1'b1, 32'h82, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h80) begin fails++; $display("[TB] FAIL misbuf_pc: got %h want %h", bus.pc_out, 32'h80); end
    checks++; if (bus.misalign !== 1'b1) begin fails++; $display("[TB] FAIL misbuf_pulse: got %b want 1", bus.misalign); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFC);
    tick();
    checks++; if (bus.misalign !== 1'b0) begin fails++; $display("[TB] FAIL wrap_mis: got %b want 0", bus.misalign); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h0) begin fails++; $display("[TB] FAIL wrap_pc: got %h want %h", bus.pc_out, 32'h0); end
    checks++; if (bus.pc_prev !== 32'hFFFFFFFC) begin fails++; $display("[TB] FAIL wrap_prev: got %h want %h", bus.pc_prev, 32'hFFFFFFFC); end
  endtask

  task automatic test_reset_in_hold();
    applyStimulus(1'b0, 3'b001, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pending !== 1'b1) begin fails++; $display("[TB] FAIL rh_pend1: got %b want 1", bus.pending); end
    applyStimulus(1'b1, 3'b001, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h0) begin fails++; $display("[TB] FAIL rh_pc: got %h want %h", bus.pc_out, 32'h0); end
    checks++; if (bus.pending !== 1'b0) begin fails++; $display("[TB] FAIL rh_pend0: got %b want 0", bus.pending); end
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    checks++; if (bus.pc_out !== 32'h4) begin fails++; $display("[TB] FAIL rh_next: got %h want %h", bus.pc_out, 32'h4); end
    checks++; if (bus.redir_taken !== 1'b0) begin fails++; $display("[TB] FAIL rh_redir: got %b want 0", bus.redir_taken); end
  endtask

  // Scenario sequence; each task starts from the PC the previous one left.
  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_sequential();
    test_stall_branch();
    test_trap_overwrite();
    test_trap_vs_branch();
    test_stalled_rules();
    test_misalign_wrap();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
